// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state type, lane width rule and byte-lane merge for data_memory_be
package data_mem_pkg;
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
    localparam int LANE_W = 8;
    function automatic int beWidth(input int dataW);
        return dataW / LANE_W;
    endfunction
    function automatic logic [LANE_W-1:0] be_merge(input logic [LANE_W-1:0] oldLane, input logic [LANE_W-1:0] newLane, input logic be);
        return be ? newLane : oldLane;
    endfunction
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: word storage with a byte-lane synchronous write port and an asynchronous read port
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH = 128,
    localparam int BE_W = beWidth(DATA_W),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;
    always_comb begin
        merged = mem[waddr];
        for (int i = 0; i < BE_W; i++)
            merged[LANE_W*i +: LANE_W] = be_merge(mem[waddr][LANE_W*i +: LANE_W], wdata[LANE_W*i +: LANE_W], wbe[i]);
    end
    always_ff @(posedge clk)
        if (we) mem[waddr] <= merged;
    assign rdata = mem[raddr];
endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: MEM-stage data memory with byte enables, valid/ready requests, range errors and a clear sweep
module data_memory_be
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH = 128,
    parameter int ADDR_W = 16,
    localparam int BE_W = beWidth(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);
    state_t state, stateNext;
    logic [AW-1:0] clrIdx, clrNext, waddr;
    logic [DATA_W-1:0] wdata, rdata;
    logic [BE_W-1:0] wbe;
    logic accept, inRange, lastIdx, we;
    assign busy = state == ST_CLEAR;
    assign req_ready = state == ST_IDLE && !clear;
    assign accept = req_valid && req_ready;
    assign inRange = req_addr < ADDR_W'(DEPTH);
    assign lastIdx = clrIdx == AW'(DEPTH - 1);
    always_comb begin
        stateNext = busy ? (lastIdx ? ST_IDLE : ST_CLEAR) : (clear ? ST_CLEAR : ST_IDLE);
        clrNext = (busy && !lastIdx) ? clrIdx + AW'(1) : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            clrIdx <= '0;
        end else begin
            state <= stateNext;
            clrIdx <= clrNext;
        end
    end
    // The sweep owns the write port; requests are never accepted while busy
    assign we = busy || (accept && req_write && inRange);
    assign waddr = busy ? clrIdx : req_addr[AW-1:0];
    assign wdata = busy ? '0 : req_wdata;
    assign wbe = busy ? '1 : req_be;
    data_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) array (
        .clk(clk),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .wbe(wbe),
        .raddr(req_addr[AW-1:0]),
        .rdata(rdata)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err <= !inRange;
                rsp_rdata <= (req_write || !inRange) ? '0 : rdata;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: directed stimulus with a response scoreboard for data_memory_be
module tb_data_memory_be;
    logic clk = 0, reset = 1, clear = 0, req_valid = 0, req_write = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic [1:0] req_be = 0;
    logic req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;
    int checks = 0, failures = 0;
    logic [32:0] expq[$];
    logic [32:0] e;
    int n;

    data_memory_be dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every response is matched against the oldest expectation
    initial forever begin
        @(negedge clk);
        if (rsp_valid) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: got rdata=0x%0h err=%0b with no request outstanding", rsp_rdata, rsp_err);
            end else begin
                e = expq.pop_front();
                if (rsp_rdata !== e[15:0] || rsp_err !== e[16]) begin
                    failures++;
                    $display("FAIL rsp addr 0x%0h: got rdata=0x%0h err=%0b, expected rdata=0x%0h err=%0b",
                             e[32:17], rsp_rdata, rsp_err, e[15:0], e[16]);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input logic [15:0] expData, input logic expErr);
        @(posedge clk); #1;
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
        @(negedge clk);
        check("req_ready", req_ready, 1);
        if (req_ready) expq.push_back({addr, expErr, expData});
    endtask

    task automatic load(input logic [15:0] addr, input logic [15:0] expData);
        issue(0, addr, 16'h0, 2'b00, expData, 0);
    endtask

    task automatic store(input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] be);
        issue(1, addr, wd, be, 16'h0, 0);
    endtask

    task automatic countBusy(output int cnt, input int limit);
        cnt = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1);
        check("reset_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);
        @(posedge clk); #1 reset = 0;
        countBusy(n, 1000);
        check("init_sweep_len", n, 128);
        check("ready_after_sweep", req_ready, 1);
        load(5, 16'h0000);
        store(3, 16'hBEEF, 2'b11);
        load(3, 16'hBEEF);
        store(3, 16'h1234, 2'b01);
        load(3, 16'hBE34);
        store(3, 16'h5600, 2'b10);
        load(3, 16'h5634);
        store(3, 16'hFFFF, 2'b00);
        load(3, 16'h5634);
        issue(0, 16'd128, 16'h0, 2'b00, 16'h0, 1);
        issue(1, 16'hFFFF, 16'hAAAA, 2'b11, 16'h0, 1);
        load(127, 16'h0000);
        for (int a = 0; a < 128; a++) load(a[15:0], a == 3 ? 16'h5634 : 16'h0000);
        for (int a = 0; a < 128; a++) store(a[15:0], 16'h00FF, 2'b11);
        load(0, 16'h00FF);
        load(127, 16'h00FF);
        // clear beats a simultaneous request
        @(posedge clk); #1;
        clear = 1; req_valid = 1; req_write = 0; req_addr = 9;
        @(negedge clk);
        check("clear_blocks_ready", req_ready, 0);
        @(posedge clk); #1;
        clear = 0; req_valid = 0;
        countBusy(n, 1000);
        check("clear_sweep_len", n, 128);
        for (int a = 0; a < 128; a++) load(a[15:0], 16'h0000);
        @(posedge clk); #1;
        req_valid = 0; clear = 1;
        @(posedge clk); #1 clear = 0;
        countBusy(n, 61);
        check("partial_sweep", n, 61);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        countBusy(n, 1000);
        check("restart_sweep_len", n, 128);
        store(7, 16'h1357, 2'b11);
        load(7, 16'h1357);
        @(posedge clk); #1;
        req_valid = 0; reset = 1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rsp_valid_after_reset", rsp_valid, 0);
        check("busy_in_reset", busy, 1);
        check("ready_in_reset", req_ready, 0);
        @(posedge clk); #1 reset = 0;
        countBusy(n, 1000);
        check("post_reset_sweep_len", n, 128);
        load(7, 16'h0000);
        @(posedge clk); #1 req_valid = 0;
        repeat (3) @(posedge clk);
        check("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
